// File: rtl/corr_window_scheduler.sv
// corr_window_scheduler
// ---------------------------------------------------------------------------
// Sequencer for the correlator datapath. Generates the probe sample strobe
// with a programmable nominal period (2^P cycles) plus pseudo-random jitter
// (0 .. 2^Jeff-1 extra cycles from a Galois LFSR), groups strobes into
// windows of 2^W samples and offers each completed window to the result path
// through a valid/ready handshake. A new window is not started until the
// previous result has been taken.
//
// Ports:
//   i_clk                 system clock (48 MHz domain)
//   i_rst_n               synchronous active-low reset
//   i_cg                  clock gate; 0 freezes all state and blanks strobes
//   i_cfgEnable           run windows back to back while high
//   i_cfgWindowLengthExp  W, window holds 2^W samples (clamped to 1..MAX)
//   i_cfgSamplePeriodExp  P, nominal sample interval 2^P cycles
//   i_cfgSampleJitterExp  J, jitter span exponent (limited to P)
//   o_sampleStrobe        one-cycle pulse: sample probes now
//   o_windowStart         coincides with the first strobe of a window
//   o_windowEnd           coincides with the last strobe of a window
//   o_resultValid         finished window result is available
//   i_resultReady         consumer accepts the result
//   o_busy                scheduler is not idle
// ---------------------------------------------------------------------------
module corr_window_scheduler #(
   parameter int          MAX_WINDOW_LENGTH_EXP = 16,
   parameter int          MAX_SAMPLE_PERIOD_EXP = 15,
   parameter int          MAX_SAMPLE_JITTER_EXP = 8,
   parameter logic [15:0] LFSR_SEED             = 16'hACE1,
   localparam int WW   = $clog2(MAX_WINDOW_LENGTH_EXP + 1),
   localparam int PW   = $clog2(MAX_SAMPLE_PERIOD_EXP + 1),
   localparam int JW   = $clog2(MAX_SAMPLE_JITTER_EXP + 1)
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_cg,
   input  logic          i_cfgEnable,
   input  logic [WW-1:0] i_cfgWindowLengthExp,
   input  logic [PW-1:0] i_cfgSamplePeriodExp,
   input  logic [JW-1:0] i_cfgSampleJitterExp,
   output logic          o_sampleStrobe,
   output logic          o_windowStart,
   output logic          o_windowEnd,
   output logic          o_resultValid,
   input  logic          i_resultReady,
   output logic          o_busy
);

   // Interval counter must hold 2^MAX_P + 2^MAX_J - 1; sample counter must
   // hold 2^MAX_W - 1 as the index of the last strobe.
   localparam int INTW = $clog2((1 << MAX_SAMPLE_PERIOD_EXP) + (1 << MAX_SAMPLE_JITTER_EXP));
   localparam int SCW  = MAX_WINDOW_LENGTH_EXP + 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      RESULT = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_nextState;
   logic [WW-1:0]     r_winExp;
   logic [PW-1:0]     r_perExp;
   logic [JW-1:0]     r_jitEff;
   logic [INTW-1:0]   r_intervalCnt;
   logic [SCW-1:0]    r_sampleCnt;
   logic [15:0]       r_lfsr;

   logic [WW-1:0]     w_clampWinExp;
   logic [PW-1:0]     w_clampPerExp;
   logic [JW-1:0]     w_clampJitEff;
   logic [MAX_SAMPLE_JITTER_EXP-1:0] w_jitterMask;
   logic [INTW-1:0]   w_interval;
   logic [SCW-1:0]    w_lastIdx;
   logic [15:0]       w_lfsrNext;
   logic              w_latchCfg;
   logic              w_strobe;
   logic              w_start;
   logic              w_end;

   function automatic int clampInt(input int value, input int lo, input int hi);
      if (value < lo) return lo;
      if (value > hi) return hi;
      return value;
   endfunction

   // Clamped view of the live configuration. The jitter exponent is limited
   // to the period exponent so the jitter never exceeds the nominal interval.
   assign w_clampWinExp = WW'(clampInt(int'(i_cfgWindowLengthExp), 1, MAX_WINDOW_LENGTH_EXP));
   assign w_clampPerExp = PW'(clampInt(int'(i_cfgSamplePeriodExp), 0, MAX_SAMPLE_PERIOD_EXP));
   assign w_clampJitEff = JW'(clampInt(clampInt(int'(i_cfgSampleJitterExp), 0, MAX_SAMPLE_JITTER_EXP),
                                       0, int'(w_clampPerExp)));

   // Low Jeff bits of the LFSR select the jitter added to 2^P.
   always_comb begin
      w_jitterMask = '0;
      for (int i = 0; i < MAX_SAMPLE_JITTER_EXP; i++) begin
         w_jitterMask[i] = (i < int'(r_jitEff));
      end
   end

   assign w_interval = (INTW'(1) << r_perExp)
                     + INTW'(r_lfsr[MAX_SAMPLE_JITTER_EXP-1:0] & w_jitterMask);
   assign w_lastIdx  = (SCW'(1) << r_winExp) - SCW'(1);

   // Right-shifting Galois form of x^16+x^14+x^13+x^11.
   assign w_lfsrNext = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);

   // Next-state and strobe decode. Strobes depend only on registered state
   // (and the gate), so the consumer's ready never reaches an output. An
   // abort (enable low in RUN) wins over a coincident window end.
   always_comb begin
      w_nextState = r_state;
      w_latchCfg  = 1'b0;
      w_strobe    = 1'b0;
      w_start     = 1'b0;
      w_end       = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_cfgEnable) begin
               w_nextState = RUN;
               w_latchCfg  = 1'b1;
            end
         end
         RUN: begin
            w_strobe = (r_intervalCnt == '0);
            w_start  = w_strobe && (r_sampleCnt == '0);
            w_end    = w_strobe && (r_sampleCnt == w_lastIdx);
            if (!i_cfgEnable) begin
               w_nextState = IDLE;
            end else if (w_end) begin
               w_nextState = RESULT;
            end
         end
         RESULT: begin
            if (i_resultReady) begin
               if (i_cfgEnable) begin
                  w_nextState = RUN;
                  w_latchCfg  = 1'b1;
               end else begin
                  w_nextState = IDLE;
               end
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
      if (!i_cg) begin
         w_nextState = r_state;
         w_latchCfg  = 1'b0;
         w_strobe    = 1'b0;
         w_start     = 1'b0;
         w_end       = 1'b0;
      end
   end

   // State, counters and LFSR. Entering RUN clears the interval counter so
   // the first strobe lands in the first RUN cycle; every strobe reloads it
   // with interval-1 and steps the LFSR once.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state       <= IDLE;
         r_winExp      <= '0;
         r_perExp      <= '0;
         r_jitEff      <= '0;
         r_intervalCnt <= '0;
         r_sampleCnt   <= '0;
         r_lfsr        <= LFSR_SEED;
      end else if (i_cg) begin
         r_state <= w_nextState;
         if (w_latchCfg) begin
            r_winExp      <= w_clampWinExp;
            r_perExp      <= w_clampPerExp;
            r_jitEff      <= w_clampJitEff;
            r_intervalCnt <= '0;
            r_sampleCnt   <= '0;
         end else if (r_state == RUN) begin
            if (w_strobe) begin
               r_intervalCnt <= w_interval - INTW'(1);
               r_sampleCnt   <= r_sampleCnt + SCW'(1);
               r_lfsr        <= w_lfsrNext;
            end else begin
               r_intervalCnt <= r_intervalCnt - INTW'(1);
            end
         end
      end
   end

   assign o_sampleStrobe = w_strobe;
   assign o_windowStart  = w_start;
   assign o_windowEnd    = w_end;
   assign o_resultValid  = (r_state == RESULT);
   assign o_busy         = (r_state != IDLE);

endmodule
